// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: valid/ready handshake carrying a payload and a
// control field. SKID=1 adds a second (skid) entry so in_ready comes straight
// off state flops; SKID=0 is a single entry with a combinational in_ready.
// Control bits read as zero whenever the stage holds nothing, so a bubble can
// never trigger a register or memory write downstream.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // Encoding equals the number of held entries, so occupancy is the state.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   main_data, skid_data;
  logic [CTRL_W-1:0]   main_ctrl, skid_ctrl;
  logic                main_valid;
  logic                accept, release_head;
  logic                main_load_in, main_load_skid, skid_load;

  assign main_valid   = (state != S_EMPTY);
  assign accept       = in_valid && in_ready;
  assign release_head = main_valid && out_ready;

  // in_ready: decode of the state flops only (SKID=1) or bypass on release (SKID=0)
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (state != S_TWO);
    end else begin : g_no_skid
      assign in_ready = (state == S_EMPTY) || out_ready;
    end
  endgenerate

  // Next-state and load-enable decode; flush drops every entry and any accept
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt      = state;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            state_nxt    = S_ONE;
            main_load_in = 1'b1;
          end
        end
        S_ONE: begin
          if (accept && release_head) begin
            main_load_in = 1'b1;
          end else if (accept && (SKID != 0)) begin
            state_nxt = S_TWO;
            skid_load = 1'b1;
          end else if (release_head) begin
            state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (release_head) begin
            state_nxt      = S_ONE;
            main_load_skid = 1'b1;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // State and entry registers; data registers hold their value on flush
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state     <= S_EMPTY;
      // NOTE: payload registers are reset too, so out_data reads zero after reset rather than X.
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= state_nxt;
      if (main_load_in) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (main_load_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (skid_load) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign occupancy = state;

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, elastic successor to the fixed ID/EX-style pipeline register.
- Carries an arbitrary data payload and control field between two pipeline stages using a valid/ready handshake.
- SKID=1 adds a skid entry so that in_ready is fully registered. Flush injects a bubble.
- Control bits are forced to zero whenever the stage holds no valid instruction, so a bubble can never write registers or memory.

Parameters:
- DATA_W, 128: payload width (pc, rd1, rd2, imm, register indices, funct fields).
- CTRL_W, 8: control field width (RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp, ...).
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bits.
- flush  in  1  synchronous kill of all held and incoming entries.
- out_valid  out  1  stage presents an instruction downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  head payload.
- out_ctrl  out  CTRL_W  head control bits; all-zero when out_valid=0.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Interface timing:
  - One clock. Reset is synchronous and active-high.
  - Priority order: reset > flush > handshake.
  - Accept occurs when in_valid & in_ready. Release occurs when out_valid & out_ready.
- Reset: main_valid=0, skid_valid=0, all data and ctrl registers=0. Outputs after reset: out_valid=0, out_ctrl=0, out_data=0, occupancy=0. in_ready=1 from the first cycle after reset deasserts.
- Internal storage: main entry (head) and skid entry.
  - out_valid = main_valid.
  - out_data = main_data.
  - out_ctrl = main_valid ? main_ctrl : 0.
- Latency: an accepted input appears at out_* on the next rising edge if the main entry is empty or being released that cycle. Order is strictly FIFO.
- SKID=1:
  - in_ready = ~skid_valid, registered with no combinational path from out_ready.
  - Empty state: an accept loads main.
  - One entry held:
    - Accept + release: load main.
    - Accept, no release: load skid.
    - Release, no accept: empty.
  - Two entries held (in_ready=0):
    - Release: skid moves to main, skid_valid=0.
    - No release: hold.
  - Accept while two entries are held is impossible, because in_ready=0.
- SKID=0:
  - in_ready = ~main_valid | out_ready (combinational).
  - Accept loads main. Release without accept clears main_valid. The skid entry is absent and occupancy[1]=0.
- Hold: with out_ready=0, main_data and main_ctrl are stable and out_valid stays 1 (stall).
- Flush:
  - Next cycle: main_valid=0, skid_valid=0, occupancy=0, out_ctrl=0.
  - Any input accepted in the flush cycle is discarded.
  - Data registers keep their old values (don't-care, but not X).
  - in_ready=1 on the next cycle.
- Reset or flush mid-stall discards both entries. There is no partial retention.
- Occupancy equals main_valid + skid_valid and updates at the same edge as the valid bits.
- Payload and ctrl pass through unmodified. There is no arithmetic. Widths are exact, with no truncation.

Test Plan:
- Reset with in_valid=1, in_data=0xAA..: hold reset 3 cycles -> out_valid=0, out_ctrl=0, occupancy=0 throughout; first accept occurs only after reset falls.
- Streaming: out_ready=1; 8 back-to-back inputs with data=0x10..0x17, ctrl=0x81 -> each appears 1 cycle later in order; in_ready never drops; occupancy ≤1.
- Backpressure (SKID=1): send A=0x1, B=0x2 with out_ready=0 -> occupancy=2, in_ready=0 the cycle after B is accepted; then out_ready=1 -> A then B on consecutive cycles; in_ready=1 the cycle after A is released.
- Flush while full: occupancy=2, assert flush with in_valid=1 (C=0x3) -> next cycle out_valid=0, out_ctrl=0x00, occupancy=0; C never appears at the output.
- Bubble ctrl masking: in_valid=0, in_ctrl=0xFF for 4 cycles -> out_ctrl=0x00 every cycle.
- SKID=0 build: out_ready=0 with A held -> in_ready=0; out_ready=1 with in_valid=1 (B) in the same cycle -> B accepted, out_data=B next cycle.
